// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg
//   Shared definitions for the pulse meter: FSM state encoding and the
//   2-bit edge codes produced by the upstream edge detector.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [1:0] CODE_LOW  = 2'b00;
    localparam logic [1:0] CODE_RISE = 2'b01;
    localparam logic [1:0] CODE_FALL = 2'b10;
    localparam logic [1:0] CODE_HIGH = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    system clock
//     rst_   asynchronous active-low reset (count -> 0)
//     clr    synchronous clear to 0 (highest priority)
//     load1  synchronous load of 1 (start of a new measurement)
//     inc    increment by one unless already at max
//     count  current value
//     at_max count is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign at_max = (count == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= ONE;
        end else if (inc && !at_max) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter
//   Measures high width and period (in clk cycles) of a signal described by
//   a per-cycle edge-code stream, and presents each completed measurement on
//   a valid/ready port. Flags dropped results (overrun) and illegal code
//   sequences (err); both flags are sticky until clr_flags.
//   Ports:
//     clk        system clock
//     rst_       asynchronous active-low reset
//     en         measurement enable; low returns to IDLE, partial count lost
//     code       edge code: 00 low, 01 rise, 10 fall, 11 high
//     clr_flags  clears overrun/err on the next edge (a new event wins)
//     ready      consumer handshake
//     valid      result available
//     high_width high cycles of the reported measurement
//     period     rise-to-rise cycles of the reported measurement
//     sat        a counter saturated during the reported measurement
//     overrun    sticky: a result was dropped while valid was pending
//     err        sticky: illegal code sequence seen
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no measurement running, waiting for a rising edge
//   HIGH  | inside the high phase, hcnt and pcnt counting
//   LOW   | inside the low phase, pcnt counting, next rise closes it
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en,
    input  logic [1:0]   code,
    input  logic         clr_flags,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] high_width,
    output logic [W-1:0] period,
    output logic         sat,
    output logic         overrun,
    output logic         err
);

    state_t       state, state_nx;
    logic         cnt_clr, cnt_load1, h_inc, p_inc;
    logic         emit, err_ev, ovr_ev, accept;
    logic [W-1:0] hcnt, pcnt;
    logic         h_max, p_max;

    sat_counter #(.W(W)) u_hcnt (
        .clk    (clk),
        .rst_   (rst_),
        .clr    (cnt_clr),
        .load1  (cnt_load1),
        .inc    (h_inc),
        .count  (hcnt),
        .at_max (h_max)
    );

    sat_counter #(.W(W)) u_pcnt (
        .clk    (clk),
        .rst_   (rst_),
        .clr    (cnt_clr),
        .load1  (cnt_load1),
        .inc    (p_inc),
        .count  (pcnt),
        .at_max (p_max)
    );

    always_comb begin
        state_nx  = state;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        h_inc     = 1'b0;
        p_inc     = 1'b0;
        emit      = 1'b0;
        err_ev    = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (code == CODE_RISE) begin
                        state_nx  = HIGH;
                        cnt_load1 = 1'b1;
                    end
                end
                HIGH: begin
                    case (code)
                        CODE_HIGH: begin
                            h_inc = 1'b1;
                            p_inc = 1'b1;
                        end
                        CODE_FALL: begin
                            state_nx = LOW;
                            p_inc    = 1'b1;
                        end
                        CODE_RISE: begin
                            err_ev    = 1'b1;
                            cnt_load1 = 1'b1;
                        end
                        default: begin
                            err_ev   = 1'b1;
                            state_nx = IDLE;
                            cnt_clr  = 1'b1;
                        end
                    endcase
                end
                LOW: begin
                    case (code)
                        CODE_LOW: begin
                            p_inc = 1'b1;
                        end
                        CODE_FALL: begin
                            err_ev = 1'b1;
                            p_inc  = 1'b1;
                        end
                        CODE_HIGH: begin
                            err_ev   = 1'b1;
                            state_nx = IDLE;
                            cnt_clr  = 1'b1;
                        end
                        default: begin
                            // Rise closes this period and opens the next one.
                            emit      = 1'b1;
                            cnt_load1 = 1'b1;
                            state_nx  = HIGH;
                        end
                    endcase
                end
                default: begin
                    state_nx = IDLE;
                    cnt_clr  = 1'b1;
                end
            endcase
        end
    end

    // A new result may replace the pending one only if it is being taken now.
    assign accept = emit && (!valid || ready);
    assign ovr_ev = emit && valid && !ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            valid      <= 1'b0;
            high_width <= '0;
            period     <= '0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                valid      <= 1'b1;
                high_width <= hcnt;
                period     <= pcnt;
                // Counters never decrease within a measurement, so at_max now
                // means max was reached at some point since the restart.
                sat        <= h_max || p_max;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (ovr_ev) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (err_ev) begin
                err <= 1'b1;
            end else if (clr_flags) begin
                err <= 1'b0;
            end
        end
    end

endmodule
